huc3_mapper: RTL and testbench
==============================

Name: huc3_mapper

Overview:
- Parametrised HuC-family cartridge mapper, the successor to the HuC1 controller.
- Adds a wider ROM bank register, a mode register covering RAM, RTC command, RTC response, semaphore and IR modes, and an RTC with a command interface and busy latency.
- Sits beside the other mappers under the cart block. Outputs are plain; the parent muxes them by `enable`.

Parameters:
- ROM_BANK_BITS, 7: ROM bank register width (up to 128 x 16 KiB banks).
- RAM_BANK_BITS, 2: RAM bank register width (8 KiB banks).
- CLK_HZ, 33554432: clk_sys frequency, used by the seconds prescaler.
- CMD_LATENCY, 4: number of ce_cpu cycles an RTC command stays busy.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  mapper selected; low holds all registers at reset values
- ce_cpu  in  1  CPU clock enable; register writes and command countdown occur only when high
- has_ram  in  1  cart has SRAM
- ram_mask  in  4  RAM bank mask
- rom_mask  in  9  ROM bank mask
- cart_addr  in  15  CPU address [14:0]
- cart_a15  in  1  CPU address bit 15
- cart_rd  in  1  ROM read strobe
- cart_wr  in  1  cart write strobe
- cart_di  in  8  CPU write data
- cram_rd  in  1  A000-BFFF read strobe
- cram_di  in  8  SRAM read data
- cram_do  out  8  data returned for A000-BFFF
- cram_addr  out  17  SRAM address
- mbc_addr  out  23  ROM byte address
- cart_oe  out  1  cart drives the bus
- ram_enabled  out  1  SRAM is readable and writable
- has_battery  out  1  constant 1

Behaviour:
- Reset values (reset_n low, or enable low):
  - mode=0x0, rom_bank=1, ram_bank=0, cmd_busy=0, busy_cnt=0, rtc_addr=0, resp=0.
  - Nibble memory and time counters are cleared by reset_n only, not by enable low.
- Writes act when ce_cpu & cart_wr & ~cart_a15, selected by cart_addr[14:13]:
  - 00: mode <= cart_di[3:0].
  - 01: rom_bank <= cart_di[ROM_BANK_BITS-1:0]; a written value of 0 maps to 1.
  - 10: ram_bank <= cart_di[RAM_BANK_BITS-1:0].
  - 11: ignored.
- ROM address:
  - 0000-3FFF uses bank 0; 4000-7FFF uses rom_bank & rom_mask.
  - mbc_addr = {zero-pad, bank, cart_addr[13:0]}.
- RAM address: cram_addr = {zero-pad, ram_bank & ram_mask, cart_addr[12:0]}.
- ram_enabled = has_ram & (mode==0x0 | mode==0xA).
- cram_do by mode:
  - 0x0 / 0xA: cram_di.
  - 0xC: {4'h8, resp}.
  - 0xD: {7'b0, ~cmd_busy}.
  - 0xE: 0xC1 (IR, no light).
  - Any other mode: 0xFF.
- cart_oe = (cart_rd & ~cart_a15) | (cram_rd & (ram_enabled | mode inside {0xC,0xD,0xE})).
- RTC commands are issued by a write to A000-BFFF with mode==0xB and cmd_busy==0:
  - cmd = di[6:4], arg = di[3:0].
  - The command executes at issue. cmd_busy then rises for CMD_LATENCY ce_cpu cycles.
  - Commands issued while busy are dropped.
- Command set, with a 16-entry nibble memory mem[] and a 4-bit rtc_addr:
  - 1: resp <= mem[rtc_addr]; rtc_addr++ (wraps F->0).
  - 3: mem[rtc_addr] <= arg; rtc_addr++.
  - 4: rtc_addr[3:0] <= arg.
  - 6, arg 0: latch. mem[0..2] <= minutes (LSN first); mem[3..5] <= days.
  - 6, arg 1: set. minutes <= mem[0..2] (saturates at 1439); days <= mem[3..5]. The seconds prescaler clears.
  - 6, arg 2: resp <= 1.
  - Other commands: no-op, but busy still asserts.
- Timekeeping, in sub-module huc3_rtc_counter:
  - Prescaler counts clk_sys cycles (not ce gated) up to CLK_HZ-1, then emits sec_tick.
  - 60 sec_ticks make one minute.
  - Minute 1439 wraps to 0 and increments days.
  - Days are 12-bit and wrap 4095 to 0.
- Simultaneous events:
  - A set command on the same cycle as a minute rollover: the set wins.
  - A latch on the same cycle as a rollover captures the pre-increment value.
  - Reset mid-busy clears busy immediately.

Decomposition:
- huc3_pkg holds:
  - Mode constants: MODE_RAM0=0x0, MODE_RAM=0xA, MODE_CMD=0xB, MODE_RESP=0xC, MODE_SEM=0xD, MODE_IR=0xE.
  - RTC command opcodes, MIN_PER_DAY=1440, IR_NO_LIGHT=0xC1.
- Sub-module huc3_rtc_counter (clk_sys, reset_n, load, load_min, load_day, minutes, days) holds the prescaler and the minute/day counters.

Test Plan:
- ROM banking: reset, read 0x4000 -> mbc_addr=0x004000. Write 0x00 to 0x2000 -> bank 1. Write 0x45 to 0x2000 with rom_mask=0x1FF -> mbc_addr=0x114000.
- RAM vs IR: mode=0xA, ram_bank=3, read 0xA010 -> cram_addr=0x06010, ram_enabled=1. mode=0xE -> cram_do=0xC1, ram_enabled=0.
- Scratch memory: mode=0xB, write 0x47 to A000 (addr=7). Wait until semaphore=1, write 0x35 to A000. Write 0x47, then 0x10 -> mode=0xC read gives 0x85.
- Busy window: issue a command, then immediately issue 0x4A -> dropped. Semaphore reads 0 for CMD_LATENCY ce cycles, then 1.
- Time rollover (CLK_HZ=4): set minutes=1439, days=5 via mem writes + 0x61. After 240 clk cycles, latch 0x60 -> mem[0..5]=0,0,0,6,0,0.
- Async reset mid-busy: drop reset_n during busy -> cmd_busy=0, rom_bank=1, mode=0 the same cycle.

Source files
------------

// File: rtl/huc3_pkg.sv
// rtl/huc3_pkg.sv - shared constants and helpers for the HuC3 mapper
// Purpose: mode values, RTC command opcodes, clock limits and the minute
//          saturation helper used by the mapper and its RTC counter.
// Ports:   none (package)
package huc3_pkg;

  // Values the mode register can select. Other nibbles read back as 0xFF.
  typedef enum logic [3:0] {
    MODE_RAM0 = 4'h0,
    MODE_RAM  = 4'hA,
    MODE_CMD  = 4'hB,
    MODE_RESP = 4'hC,
    MODE_SEM  = 4'hD,
    MODE_IR   = 4'hE
  } huc3_mode_e;

  // RTC command opcodes carried in di[6:4] of a command write.
  typedef enum logic [2:0] {
    CMD_READ  = 3'd1,
    CMD_WRITE = 3'd3,
    CMD_ADDR  = 3'd4,
    CMD_EXT   = 3'd6
  } huc3_cmd_e;

  // Sub-operations of CMD_EXT, selected by the argument nibble.
  localparam logic [3:0] EXT_LATCH = 4'h0;
  localparam logic [3:0] EXT_SET   = 4'h1;
  localparam logic [3:0] EXT_PING  = 4'h2;

  localparam int         MIN_PER_DAY = 1440;
  localparam logic [7:0] IR_NO_LIGHT = 8'hC1;

  // Minutes loaded from scratch memory are a raw 12-bit value; anything past
  // the last minute of a day is clamped rather than wrapped.
  function automatic logic [10:0] sat_minutes(input logic [11:0] m);
    if (m > 12'(MIN_PER_DAY - 1)) begin
      return 11'(MIN_PER_DAY - 1);
    end
    return m[10:0];
  endfunction

endpackage

// File: rtl/huc3_rtc_counter.sv
// rtl/huc3_rtc_counter.sv - seconds prescaler plus minute/day counters
// Purpose: free-running timekeeping for the HuC3 RTC, loadable by a set command.
// Ports:   clk_sys  - system clock (prescaler counts every cycle, no ce gating)
//          reset_n  - asynchronous active-low reset
//          load     - one-cycle pulse loading minutes/days, clears prescaler
//          load_min - raw 12-bit minutes (saturated to 1439 on load)
//          load_day - 12-bit day count to load
//          minutes  - current minute of day, 0..1439
//          days     - current day count, wraps 4095 -> 0
module huc3_rtc_counter
  import huc3_pkg::*;
#(
  parameter int CLK_HZ = 33554432
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        load,
  input  logic [11:0] load_min,
  input  logic [11:0] load_day,
  output logic [10:0] minutes,
  output logic [11:0] days
);

  localparam int            PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [10:0]   MIN_LAST  = 11'(MIN_PER_DAY - 1);

  logic [PW-1:0] presc;
  logic [5:0]    secs;
  logic          sec_tick;

  assign sec_tick = (presc == PRESC_MAX);

  // A load takes priority over a rollover on the same edge. The seconds
  // count clears with the prescaler so a set marks an exact minute boundary.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      presc   <= '0;
      secs    <= '0;
      minutes <= '0;
      days    <= '0;
    end else if (load) begin
      presc   <= '0;
      secs    <= '0;
      minutes <= sat_minutes(load_min);
      days    <= load_day;
    end else begin
      presc <= sec_tick ? '0 : presc + 1'b1;
      if (sec_tick) begin
        if (secs == 6'd59) begin
          secs <= '0;
          if (minutes == MIN_LAST) begin
            minutes <= '0;
            days    <= days + 12'd1;
          end else begin
            minutes <= minutes + 11'd1;
          end
        end else begin
          secs <= secs + 6'd1;
        end
      end
    end
  end

endmodule

// File: rtl/huc3_mapper.sv
// rtl/huc3_mapper.sv - HuC3 cartridge mapper with RTC command interface
// Purpose: ROM/RAM banking, mode register, RTC scratch memory and commands.
// Ports:   clk_sys, reset_n (async active-low), enable (low holds reset values),
//          ce_cpu (write/countdown enable), has_ram, ram_mask, rom_mask,
//          cart_addr/cart_a15 (CPU address), cart_rd, cart_wr, cart_di,
//          cram_rd, cram_di (SRAM data in), cram_do (A000-BFFF read data),
//          cram_addr (SRAM address), mbc_addr (ROM byte address), cart_oe,
//          ram_enabled, has_battery (constant 1).
module huc3_mapper
  import huc3_pkg::*;
#(
  parameter int ROM_BANK_BITS = 7,
  parameter int RAM_BANK_BITS = 2,
  parameter int CLK_HZ        = 33554432,
  parameter int CMD_LATENCY   = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        ce_cpu,
  input  logic        has_ram,
  input  logic [3:0]  ram_mask,
  input  logic [8:0]  rom_mask,
  input  logic [14:0] cart_addr,
  input  logic        cart_a15,
  input  logic        cart_rd,
  input  logic        cart_wr,
  input  logic [7:0]  cart_di,
  input  logic        cram_rd,
  input  logic [7:0]  cram_di,
  output logic [7:0]  cram_do,
  output logic [16:0] cram_addr,
  output logic [22:0] mbc_addr,
  output logic        cart_oe,
  output logic        ram_enabled,
  output logic        has_battery
);

  localparam int BW = $clog2(CMD_LATENCY + 1);

  logic [3:0]               mode;
  logic [ROM_BANK_BITS-1:0] rom_bank;
  logic [RAM_BANK_BITS-1:0] ram_bank;
  logic                     cmd_busy;
  logic [BW-1:0]            busy_cnt;
  logic [3:0]               rtc_addr;
  logic [3:0]               resp;
  logic [3:0]               mem [16];

  logic [10:0] minutes;
  logic [11:0] days;
  logic [11:0] minutes12;

  logic       reg_wr;
  logic       ram_wr;
  logic       cmd_issue;
  logic [2:0] cmd;
  logic [3:0] arg;
  logic       do_latch;
  logic       do_set;
  logic [8:0] rom_bank_sel;
  logic       unused_di7;

  assign unused_di7 = cart_di[7];

  assign reg_wr    = enable & ce_cpu & cart_wr & ~cart_a15;
  assign ram_wr    = enable & ce_cpu & cart_wr & cart_a15 & (cart_addr[14:13] == 2'b01);
  // Commands only start when idle; writes landing during busy are dropped.
  assign cmd_issue = ram_wr & (mode == MODE_CMD) & ~cmd_busy;
  assign cmd       = cart_di[6:4];
  assign arg       = cart_di[3:0];
  assign do_latch  = cmd_issue & (cmd == CMD_EXT) & (arg == EXT_LATCH);
  assign do_set    = cmd_issue & (cmd == CMD_EXT) & (arg == EXT_SET);
  assign minutes12 = {1'b0, minutes};

  huc3_rtc_counter #(
    .CLK_HZ(CLK_HZ)
  ) u_rtc (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .load    (do_set),
    .load_min({mem[2], mem[1], mem[0]}),
    .load_day({mem[5], mem[4], mem[3]}),
    .minutes (minutes),
    .days    (days)
  );

  // Control registers: cleared by reset_n and held cleared while disabled.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mode     <= MODE_RAM0;
      rom_bank <= ROM_BANK_BITS'(1);
      ram_bank <= '0;
      cmd_busy <= 1'b0;
      busy_cnt <= '0;
      rtc_addr <= '0;
      resp     <= '0;
    end else if (!enable) begin
      mode     <= MODE_RAM0;
      rom_bank <= ROM_BANK_BITS'(1);
      ram_bank <= '0;
      cmd_busy <= 1'b0;
      busy_cnt <= '0;
      rtc_addr <= '0;
      resp     <= '0;
    end else begin
      if (reg_wr) begin
        case (cart_addr[14:13])
          2'b00: mode <= cart_di[3:0];
          2'b01: rom_bank <= (cart_di[ROM_BANK_BITS-1:0] == '0) ?
                             ROM_BANK_BITS'(1) : cart_di[ROM_BANK_BITS-1:0];
          2'b10: ram_bank <= cart_di[RAM_BANK_BITS-1:0];
          default: ;
        endcase
      end
      if (cmd_issue) begin
        cmd_busy <= 1'b1;
        busy_cnt <= BW'(CMD_LATENCY);
        case (cmd)
          CMD_READ: begin
            resp     <= mem[rtc_addr];
            rtc_addr <= rtc_addr + 4'd1;
          end
          CMD_WRITE: rtc_addr <= rtc_addr + 4'd1;
          CMD_ADDR:  rtc_addr <= arg;
          CMD_EXT:   if (arg == EXT_PING) resp <= 4'h1;
          default: ;
        endcase
      end else if (cmd_busy && ce_cpu) begin
        busy_cnt <= busy_cnt - BW'(1);
        if (busy_cnt == BW'(1)) begin
          cmd_busy <= 1'b0;
        end
      end
    end
  end

  // Scratch nibble memory survives enable low; only reset_n clears it.
  // A latch reads the counter registers, so a same-edge rollover is not seen.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] <= '0;
      end
    end else if (cmd_issue) begin
      if (cmd == CMD_WRITE) begin
        mem[rtc_addr] <= arg;
      end else if (do_latch) begin
        mem[0] <= minutes12[3:0];
        mem[1] <= minutes12[7:4];
        mem[2] <= minutes12[11:8];
        mem[3] <= days[3:0];
        mem[4] <= days[7:4];
        mem[5] <= days[11:8];
      end
    end
  end

  always_comb begin
    rom_bank_sel = '0;
    if (cart_addr[14]) begin
      rom_bank_sel = 9'(rom_bank) & rom_mask;
    end
  end

  assign mbc_addr    = {rom_bank_sel, cart_addr[13:0]};
  assign cram_addr   = {(4'(ram_bank) & ram_mask), cart_addr[12:0]};
  assign ram_enabled = has_ram & ((mode == MODE_RAM0) | (mode == MODE_RAM));
  assign has_battery = 1'b1;

  always_comb begin
    cram_do = 8'hFF;
    case (mode)
      MODE_RAM0, MODE_RAM: cram_do = cram_di;
      MODE_RESP:           cram_do = {4'h8, resp};
      MODE_SEM:            cram_do = {7'b0, ~cmd_busy};
      MODE_IR:             cram_do = IR_NO_LIGHT;
      default:             cram_do = 8'hFF;
    endcase
  end

  assign cart_oe = (cart_rd & ~cart_a15) |
                   (cram_rd & (ram_enabled | (mode == MODE_RESP) |
                               (mode == MODE_SEM) | (mode == MODE_IR)));

endmodule

// File: tb/tb_huc3_mapper.sv
// tb/tb_huc3_mapper.sv - self-checking bench for huc3_mapper
module tb_huc3_mapper;

  localparam int     ROM_BANK_BITS = 7;
  localparam int     RAM_BANK_BITS = 2;
  localparam int     CLK_HZ        = 4;
  localparam int     CMD_LATENCY   = 4;
  localparam longint MIN_CYC       = CLK_HZ * 60;

  logic        clk_sys   = 1'b0;
  logic        reset_n   = 1'b0;
  logic        enable    = 1'b1;
  logic        ce_cpu    = 1'b1;
  logic        has_ram   = 1'b1;
  logic [3:0]  ram_mask  = 4'hF;
  logic [8:0]  rom_mask  = 9'h1FF;
  logic [14:0] cart_addr = '0;
  logic        cart_a15  = 1'b0;
  logic        cart_rd   = 1'b0;
  logic        cart_wr   = 1'b0;
  logic [7:0]  cart_di   = '0;
  logic        cram_rd   = 1'b0;
  logic [7:0]  cram_di   = 8'h5A;
  logic [7:0]  cram_do;
  logic [16:0] cram_addr;
  logic [22:0] mbc_addr;
  logic        cart_oe;
  logic        ram_enabled;
  logic        has_battery;

  huc3_mapper #(
    .ROM_BANK_BITS(ROM_BANK_BITS),
    .RAM_BANK_BITS(RAM_BANK_BITS),
    .CLK_HZ       (CLK_HZ),
    .CMD_LATENCY  (CMD_LATENCY)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .enable     (enable),
    .ce_cpu     (ce_cpu),
    .has_ram    (has_ram),
    .ram_mask   (ram_mask),
    .rom_mask   (rom_mask),
    .cart_addr  (cart_addr),
    .cart_a15   (cart_a15),
    .cart_rd    (cart_rd),
    .cart_wr    (cart_wr),
    .cart_di    (cart_di),
    .cram_rd    (cram_rd),
    .cram_di    (cram_di),
    .cram_do    (cram_do),
    .cram_addr  (cram_addr),
    .mbc_addr   (mbc_addr),
    .cart_oe    (cart_oe),
    .ram_enabled(ram_enabled),
    .has_battery(has_battery)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: register values as plain integers, busy as a ce-edge
  // distance from the issuing edge, time as elapsed cycles since a base.
  int     m_mode, m_rom, m_ram, m_addr, m_resp;
  int     m_mem [16];
  bit     m_busy_v;
  longint m_ce_cnt, m_issue_ce;
  longint m_cyc, m_base_cyc, m_base_total;

  function automatic longint now_total();
    return m_base_total + (m_cyc - m_base_cyc) / MIN_CYC;
  endfunction

  function automatic bit m_busy();
    return m_busy_v && ((m_ce_cnt - m_issue_ce) < CMD_LATENCY);
  endfunction

  task automatic model_regs_reset();
    m_mode = 0; m_rom = 1; m_ram = 0; m_addr = 0; m_resp = 0; m_busy_v = 0;
  endtask

  task automatic model_full_reset();
    model_regs_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 0;
    m_cyc = 0; m_base_cyc = 0; m_base_total = 0; m_ce_cnt = 0; m_issue_ce = 0;
  endtask

  task automatic exec_cmd(input int cmd, input int arg, input longint total);
    int mn, dy;
    case (cmd)
      1: begin m_resp = m_mem[m_addr]; m_addr = (m_addr + 1) % 16; end
      3: begin m_mem[m_addr] = arg; m_addr = (m_addr + 1) % 16; end
      4: m_addr = arg;
      6: begin
        if (arg == 0) begin
          mn = int'(total % 1440);
          dy = int'((total / 1440) % 4096);
          m_mem[0] = mn % 16; m_mem[1] = (mn / 16) % 16; m_mem[2] = mn / 256;
          m_mem[3] = dy % 16; m_mem[4] = (dy / 16) % 16; m_mem[5] = dy / 256;
        end else if (arg == 1) begin
          mn = m_mem[0] + 16 * m_mem[1] + 256 * m_mem[2];
          if (mn > 1439) mn = 1439;
          dy = m_mem[3] + 16 * m_mem[4] + 256 * m_mem[5];
          m_base_total = longint'(mn) + longint'(dy) * 1440;
          m_base_cyc   = m_cyc;
        end else if (arg == 2) begin
          m_resp = 1;
        end
      end
      default: ;
    endcase
    m_busy_v   = 1;
    m_issue_ce = m_ce_cnt;
  endtask

  task automatic model_edge();
    longint total;
    bit     busy_before;
    int     di;
    total       = now_total();
    busy_before = m_busy();
    di          = int'(cart_di);
    if (ce_cpu) m_ce_cnt++;
    m_cyc++;
    if (!enable) begin
      model_regs_reset();
    end else if (ce_cpu && cart_wr) begin
      if (!cart_a15) begin
        case (int'(cart_addr[14:13]))
          0: m_mode = di % 16;
          1: m_rom  = ((di % 128) == 0) ? 1 : di % 128;
          2: m_ram  = di % 4;
          default: ;
        endcase
      end else if (cart_addr[14:13] == 2'b01 && m_mode == 11 && !busy_before) begin
        exec_cmd((di / 16) % 8, di % 16, total);
      end
    end
  endtask

  initial begin
    model_full_reset();
    forever begin
      @(posedge clk_sys or negedge reset_n);
      if (!reset_n) model_full_reset();
      else model_edge();
    end
  end

  // Compare process: every output against the model, once per cycle.
  initial begin
    int bank, e_do;
    bit e_ren, e_oe;
    forever begin
      @(negedge clk_sys);
      bank  = cart_addr[14] ? (m_rom & int'(rom_mask)) : 0;
      e_ren = has_ram && (m_mode == 0 || m_mode == 10);
      case (m_mode)
        0, 10:   e_do = int'(cram_di);
        12:      e_do = 128 + m_resp;
        13:      e_do = m_busy() ? 0 : 1;
        14:      e_do = 193;
        default: e_do = 255;
      endcase
      e_oe = (cart_rd && !cart_a15) ||
             (cram_rd && (e_ren || m_mode == 12 || m_mode == 13 || m_mode == 14));
      check("mbc_addr", mbc_addr, bank * 16384 + int'(cart_addr[13:0]));
      check("cram_addr", cram_addr, (m_ram & int'(ram_mask)) * 8192 + int'(cart_addr[12:0]));
      check("ram_enabled", ram_enabled, e_ren);
      check("cram_do", cram_do, e_do);
      check("cart_oe", cart_oe, e_oe);
      check("has_battery", has_battery, 1);
    end
  end

  // Stimulus helpers; each returns at negedge + 1.
  task automatic idle(input int n);
    repeat (n) begin @(negedge clk_sys); #1; end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cart_a15 = a[15]; cart_addr = a[14:0]; cart_di = d; cart_wr = 1'b1;
    @(negedge clk_sys); #1;
    cart_wr = 1'b0;
  endtask

  task automatic set_rd(input logic [15:0] a);
    cart_a15 = a[15]; cart_addr = a[14:0]; cart_rd = 1'b1; cram_rd = 1'b1; cart_wr = 1'b0;
    #1;
  endtask

  task automatic step();
    @(negedge clk_sys); #1;
    cart_rd = 1'b0; cram_rd = 1'b0;
  endtask

  task automatic rtc_cmd(input logic [7:0] d);
    wr(16'hA000, d);
    idle(CMD_LATENCY + 1);
  endtask

  task automatic set_time(input logic [11:0] mn, input logic [11:0] dy);
    wr(16'h0000, 8'h0B);
    rtc_cmd(8'h40);
    rtc_cmd({4'h3, mn[3:0]});  rtc_cmd({4'h3, mn[7:4]});  rtc_cmd({4'h3, mn[11:8]});
    rtc_cmd({4'h3, dy[3:0]});  rtc_cmd({4'h3, dy[7:4]});  rtc_cmd({4'h3, dy[11:8]});
    rtc_cmd(8'h61);
  endtask

  task automatic check_nib(input int idx, input int exp);
    wr(16'h0000, 8'h0B);
    rtc_cmd(8'h40 | 8'(idx));
    rtc_cmd(8'h10);
    wr(16'h0000, 8'h0C);
    set_rd(16'hA000);
    check($sformatf("mem%0d", idx), cram_do, 8'h80 | 8'(exp));
    step();
  endtask

  task automatic check_six(input string tag, input int n0, input int n1, input int n2,
                           input int n3, input int n4, input int n5);
    $display("checking %s", tag);
    check_nib(0, n0); check_nib(1, n1); check_nib(2, n2);
    check_nib(3, n3); check_nib(4, n4); check_nib(5, n5);
  endtask

  logic [7:0] mode_tab [8] = '{8'h00, 8'h0A, 8'h0B, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h07};
  int         cmd_tab  [8] = '{1, 3, 4, 6, 6, 1, 0, 7};

  initial begin
    int r, c;
    logic [15:0] a;

    repeat (3) @(negedge clk_sys);
    #1 reset_n = 1'b1;

    // Reset state and ROM banking
    set_rd(16'h4000);
    check("reset_mbc", mbc_addr, 32'h004000);
    check("reset_ram_en", ram_enabled, 1);
    check("reset_cram_do", cram_do, 8'h5A);
    step();
    wr(16'h2000, 8'h00);
    set_rd(16'h4000);
    check("bank0_maps_1", mbc_addr, 32'h004000);
    step();
    wr(16'h2000, 8'h45);
    set_rd(16'h4000);
    check("bank_45", mbc_addr, 32'h114000);
    step();
    set_rd(16'h1234);
    check("low_rom", mbc_addr, 32'h001234);
    step();

    // RAM vs IR
    wr(16'h0000, 8'h0A);
    wr(16'h4000, 8'h03);
    set_rd(16'hA010);
    check("ram_addr", cram_addr, 32'h06010);
    check("ram_en_A", ram_enabled, 1);
    step();
    wr(16'h0000, 8'h0E);
    set_rd(16'hA010);
    check("ir_do", cram_do, 8'hC1);
    check("ir_ram_en", ram_enabled, 0);
    check("ir_oe", cart_oe, 1);
    step();

    // Scratch memory
    wr(16'h0000, 8'h0B);
    rtc_cmd(8'h47); rtc_cmd(8'h35); rtc_cmd(8'h47); rtc_cmd(8'h10);
    wr(16'h0000, 8'h0C);
    set_rd(16'hA000);
    check("scratch_resp", cram_do, 8'h85);
    step();

    // Busy window: second command dropped, semaphore low for CMD_LATENCY ce edges
    wr(16'h0000, 8'h0B);
    rtc_cmd(8'h47);
    wr(16'hA000, 8'h62);
    wr(16'hA000, 8'h4A);
    wr(16'h0000, 8'h0D);
    set_rd(16'hA000);
    check("sem_k2", cram_do, 8'h00);
    ce_cpu = 1'b0;
    idle(5);
    check("sem_ce_hold", cram_do, 8'h00);
    ce_cpu = 1'b1;
    idle(1);
    check("sem_k3", cram_do, 8'h00);
    idle(1);
    check("sem_k4", cram_do, 8'h01);
    step();
    wr(16'h0000, 8'h0C);
    set_rd(16'hA000);
    check("ping_resp", cram_do, 8'h81);
    step();
    wr(16'h0000, 8'h0B);
    rtc_cmd(8'h10);
    wr(16'h0000, 8'h0C);
    set_rd(16'hA000);
    check("drop_kept_addr", cram_do, 8'h85);
    step();

    // Saturating set, immediate latch
    set_time(12'hFFF, 12'h123);
    rtc_cmd(8'h60);
    check_six("saturation", 15, 9, 5, 3, 2, 1);

    // Minute rollover into next day
    set_time(12'd1439, 12'd5);
    idle(300);
    wr(16'h0000, 8'h0B);
    rtc_cmd(8'h60);
    check_six("rollover", 0, 0, 0, 6, 0, 0);

    // Enable low resets registers but keeps scratch memory
    wr(16'h2000, 8'h22);
    enable = 1'b0;
    idle(1);
    set_rd(16'h4000);
    check("disable_bank", mbc_addr, 32'h004000);
    step();
    enable = 1'b1;
    check_nib(3, 6);

    // Day counter wrap
    set_time(12'd1439, 12'd4095);
    idle(300);
    wr(16'h0000, 8'h0B);
    rtc_cmd(8'h60);
    check_six("day_wrap", 0, 0, 0, 0, 0, 0);

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      ce_cpu  = ($urandom_range(0, 3) != 0);
      enable  = ($urandom_range(0, 199) != 0);
      has_ram = ($urandom_range(0, 7) != 0);
      cart_rd = 1'($urandom_range(0, 1));
      cram_rd = 1'($urandom_range(0, 1));
      cram_di = 8'($urandom);
      if ($urandom_range(0, 63) == 0) rom_mask = 9'($urandom);
      if ($urandom_range(0, 63) == 0) ram_mask = 4'($urandom);
      a = 16'($urandom);
      r = $urandom_range(0, 9);
      cart_wr = (r < 9);
      case (r)
        0, 1, 2: begin
          a = {3'b000, a[12:0]};
          cart_di = mode_tab[$urandom_range(0, 7)] | 8'($urandom_range(0, 15) << 4);
        end
        3: begin a = {3'b001, a[12:0]}; cart_di = 8'($urandom); end
        4: begin a = {3'b010, a[12:0]}; cart_di = 8'($urandom); end
        5, 6, 7: begin
          a = {3'b101, a[12:0]};
          c = cmd_tab[$urandom_range(0, 7)];
          cart_di = {1'($urandom), 3'(c),
                     (c == 6) ? 4'($urandom_range(0, 3)) : 4'($urandom)};
        end
        default: cart_di = 8'($urandom);
      endcase
      cart_a15 = a[15];
      cart_addr = a[14:0];
      @(negedge clk_sys); #1;
    end
    cart_wr = 1'b0; ce_cpu = 1'b1; enable = 1'b1; has_ram = 1'b1;
    rom_mask = 9'h1FF; ram_mask = 4'hF; cram_di = 8'h3C;
    idle(2);

    // Async reset in the middle of a busy window
    wr(16'h2000, 8'h45);
    wr(16'h0000, 8'h0B);
    wr(16'hA000, 8'h62);
    set_rd(16'h4000);
    reset_n = 1'b0;
    #1;
    check("rst_bank", mbc_addr, 32'h004000);
    check("rst_mode_ram_en", ram_enabled, 1);
    check("rst_mode_do", cram_do, 8'h3C);
    step();
    idle(1);
    reset_n = 1'b1;
    wr(16'h0000, 8'h0D);
    set_rd(16'hA000);
    check("rst_busy_clear", cram_do, 8'h01);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
